border_hit_scheduler: RTL

//  Collects per-ball border hits during the pixel scan and applies velocity reflections once per frame.

---
 rtl/hit_pkg.sv | 29 ++
 rtl/border_reflect.sv | 36 +++
 rtl/border_hit_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hit_pkg.sv
// rtl/hit_pkg.sv - shared types, border defaults and helpers for the border hit scheduler
package hit_pkg;

    typedef logic signed [10:0] coord_t;
    typedef logic signed [10:0] vel_t;

    typedef enum logic [1:0] {IDLE, SCAN, CALC, ISSUE} hit_state_t;

    localparam int DEF_TOP_OFFSET   = 32;
    localparam int DEF_DOWN_OFFSET  = 448;
    localparam int DEF_LEFT_OFFSET  = 32;
    localparam int DEF_RIGHT_OFFSET = 608;
    localparam int DEF_BALL_SIZE    = 32;
    localparam int VEL_MAX          = 1023;

    // One extra bit of headroom so pos+SIZE never wraps.
    function automatic logic signed [11:0] ext12(input coord_t c);
        return {c[10], c};
    endfunction

    function automatic vel_t neg_sat(input vel_t v);
        logic signed [11:0] n;
        n = -$signed({v[10], v});
        if (n > 12'sd1023)
            return 11'(VEL_MAX);
        return n[10:0];
    endfunction

endpackage

// File: rtl/border_reflect.sv
// rtl/border_reflect.sv - combinational velocity reflection against the four borders
module border_reflect
    import hit_pkg::*;
#(
    parameter int TOP_OFFSET   = DEF_TOP_OFFSET,
    parameter int DOWN_OFFSET  = DEF_DOWN_OFFSET,
    parameter int LEFT_OFFSET  = DEF_LEFT_OFFSET,
    parameter int RIGHT_OFFSET = DEF_RIGHT_OFFSET,
    parameter int BALL_SIZE    = DEF_BALL_SIZE
)(
    input  coord_t posX,
    input  coord_t posY,
    input  vel_t   velX,
    input  vel_t   velY,
    output vel_t   newVelX,
    output vel_t   newVelY
);

    localparam logic signed [11:0] TOP_C   = 12'(TOP_OFFSET);
    localparam logic signed [11:0] DOWN_C  = 12'(DOWN_OFFSET);
    localparam logic signed [11:0] LEFT_C  = 12'(LEFT_OFFSET);
    localparam logic signed [11:0] RIGHT_C = 12'(RIGHT_OFFSET);
    localparam logic signed [11:0] SZ_C    = 12'(BALL_SIZE);

    logic hit_x, hit_y;

    always_comb begin
        hit_x = (ext12(posX) <= LEFT_C) || (ext12(posX) + SZ_C >= RIGHT_C);
        hit_y = (ext12(posY) <= TOP_C)  || (ext12(posY) + SZ_C >= DOWN_C);
    end

    // A ball that already left the border keeps its velocity.
    assign newVelX = hit_x ? neg_sat(velX) : velX;
    assign newVelY = hit_y ? neg_sat(velY) : velY;

endmodule

// File: rtl/border_hit_scheduler.sv
// rtl/border_hit_scheduler.sv - captures per-ball border hits and issues one reflection per ball per frame
module border_hit_scheduler
    import hit_pkg::*;
#(
    parameter int NUM_BALLS    = 4,
    parameter int TOP_OFFSET   = DEF_TOP_OFFSET,
    parameter int DOWN_OFFSET  = DEF_DOWN_OFFSET,
    parameter int LEFT_OFFSET  = DEF_LEFT_OFFSET,
    parameter int RIGHT_OFFSET = DEF_RIGHT_OFFSET,
    parameter int BALL_SIZE    = DEF_BALL_SIZE
)(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [NUM_BALLS-1:0]   ballDR,
    input  logic                   bordersDR,
    input  logic [NUM_BALLS*11-1:0] ballPosX,
    input  logic [NUM_BALLS*11-1:0] ballPosY,
    input  logic [NUM_BALLS*11-1:0] ballVelX,
    input  logic [NUM_BALLS*11-1:0] ballVelY,
    input  logic                   updReady,
    output logic                   updValid,
    output logic [3:0]             updIdx,
    output vel_t                   updVelX,
    output vel_t                   updVelY,
    output logic                   collisionOccurred,
    output logic                   overrun
);

    localparam logic signed [11:0] TOP_C   = 12'(TOP_OFFSET);
    localparam logic signed [11:0] DOWN_C  = 12'(DOWN_OFFSET);
    localparam logic signed [11:0] LEFT_C  = 12'(LEFT_OFFSET);
    localparam logic signed [11:0] RIGHT_C = 12'(RIGHT_OFFSET);
    localparam logic signed [11:0] SZ_C    = 12'(BALL_SIZE);

    hit_state_t             state, state_nxt;
    logic [NUM_BALLS-1:0]   pending, armed, svc_mask, inside_v, hits, clr_mask;
    logic [3:0]             idx, low_idx;
    coord_t                 sel_px, sel_py;
    vel_t                   sel_vx, sel_vy, refl_vx, refl_vy, velx_q, vely_q;
    logic                   snap, accept;

    // Arming wins over a hit: a ball fully inside cannot register a border hit.
    always_comb begin
        inside_v = '0;
        hits     = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            inside_v[i] = (ext12(ballPosX[i*11 +: 11]) > LEFT_C) &&
                          (ext12(ballPosX[i*11 +: 11]) + SZ_C < RIGHT_C) &&
                          (ext12(ballPosY[i*11 +: 11]) > TOP_C) &&
                          (ext12(ballPosY[i*11 +: 11]) + SZ_C < DOWN_C);
            hits[i] = ballDR[i] & bordersDR & armed[i] & ~inside_v[i];
        end
    end

    always_comb begin
        low_idx  = '0;
        sel_px   = '0;
        sel_py   = '0;
        sel_vx   = '0;
        sel_vy   = '0;
        clr_mask = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (svc_mask[i])
                low_idx = 4'(i);
        end
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx == 4'(i)) begin
                sel_px      = coord_t'(ballPosX[i*11 +: 11]);
                sel_py      = coord_t'(ballPosY[i*11 +: 11]);
                sel_vx      = vel_t'(ballVelX[i*11 +: 11]);
                sel_vy      = vel_t'(ballVelY[i*11 +: 11]);
                clr_mask[i] = 1'b1;
            end
        end
    end

    border_reflect #(
        .TOP_OFFSET  (TOP_OFFSET),
        .DOWN_OFFSET (DOWN_OFFSET),
        .LEFT_OFFSET (LEFT_OFFSET),
        .RIGHT_OFFSET(RIGHT_OFFSET),
        .BALL_SIZE   (BALL_SIZE)
    ) u_reflect (
        .posX   (sel_px),
        .posY   (sel_py),
        .velX   (sel_vx),
        .velY   (sel_vy),
        .newVelX(refl_vx),
        .newVelY(refl_vy)
    );

    assign snap   = (state == IDLE) && startOfFrame;
    assign accept = updValid && updReady;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (startOfFrame) state_nxt = SCAN;
            SCAN:  state_nxt = (svc_mask == '0) ? IDLE : CALC;
            CALC:  state_nxt = ISSUE;
            ISSUE: if (updReady) state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        updValid          = (state == ISSUE);
        collisionOccurred = (state == ISSUE) && updReady;
        overrun           = startOfFrame && (state != IDLE);
    end

    // Hits seen in the snapshot cycle itself belong to the next frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending  <= '0;
            armed    <= '1;
            svc_mask <= '0;
            idx      <= '0;
            velx_q   <= '0;
            vely_q   <= '0;
        end else begin
            armed <= (armed & ~hits) | inside_v;
            if (snap) begin
                svc_mask <= pending;
                pending  <= hits;
            end else begin
                pending <= pending | hits;
                if (accept)
                    svc_mask <= svc_mask & ~clr_mask;
            end
            if (state == SCAN)
                idx <= low_idx;
            if (state == CALC) begin
                velx_q <= refl_vx;
                vely_q <= refl_vy;
            end
        end
    end

    assign updIdx  = idx;
    assign updVelX = velx_q;
    assign updVelY = vely_q;

endmodule
